// File: rtl/game_sched.sv
// Game flow controller for the dinosaur runner: IDLE/RUN/DEAD sequencing, collision, score and enemy step pacing.
// Optional GAME_SCHED_HISCORE_EN adds a hiscore output that keeps the best score across restarts.
module game_sched #(
    parameter int DATALEN      = 20,
    parameter int DATACOUNT    = 4,
    parameter int X_W          = 10,
    parameter int Y_W          = 10,
    parameter int OBJ_W        = 16,
    parameter int OBJ_H        = 16,
    parameter int START_PERIOD = 4,
    parameter int MIN_PERIOD   = 1,
    parameter int SPEEDUP_PTS  = 100,
    parameter int DEAD_HOLD    = 30
) (
    input  logic                           clock,
    input  logic                           rst,
    input  logic                           frame_tick,
    input  logic                           jump,
    input  logic [DATALEN*DATACOUNT-1:0]   gamedata,
    output logic                           run,
    output logic                           game_over,
    output logic                           enemy_step,
    output logic [13:0]                    score,
    output logic [2:0]                     period
`ifdef GAME_SCHED_HISCORE_EN
    ,
    output logic [13:0]                    hiscore
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    localparam int PTS_W  = $clog2(SPEEDUP_PTS);
    localparam int HOLD_W = $clog2(DEAD_HOLD + 1);

    localparam logic [13:0]       SCORE_MAX = 14'd9999;
    localparam logic [2:0]        PER_START = 3'(START_PERIOD);
    localparam logic [2:0]        PER_MIN   = 3'(MIN_PERIOD);
    localparam logic [PTS_W-1:0]  PTS_LAST  = PTS_W'(SPEEDUP_PTS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(DEAD_HOLD);
    localparam logic [X_W:0]      OBJ_WX    = (X_W + 1)'(OBJ_W);
    localparam logic [Y_W:0]      OBJ_HY    = (Y_W + 1)'(OBJ_H);

    logic [1:0]        state;
    logic              jump_prev;
    logic              jp;
    logic [2:0]        fcnt;
    logic [PTS_W-1:0]  pts;
    logic [HOLD_W-1:0] hold;
    logic              coll;
    logic [X_W:0]      px, ex;
    logic [Y_W:0]      py, ey;

    assign jp = jump & ~jump_prev;

    // One extra bit on every coordinate keeps the box-edge sums from wrapping.
    always_comb begin
        px   = {1'b0, gamedata[X_W-1:0]};
        py   = {1'b0, gamedata[DATALEN-1:X_W]};
        ex   = '0;
        ey   = '0;
        coll = 1'b0;
        for (int unsigned i = 1; i < DATACOUNT; i++) begin
            ex = {1'b0, gamedata[i*DATALEN +: X_W]};
            ey = {1'b0, gamedata[i*DATALEN + X_W +: Y_W]};
            if ((ex != '0) && (px < ex + OBJ_WX) && (ex < px + OBJ_WX) &&
                (py < ey + OBJ_HY) && (ey < py + OBJ_HY))
                coll = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state      <= ST_IDLE;
            run        <= 1'b0;
            game_over  <= 1'b0;
            enemy_step <= 1'b0;
            score      <= '0;
            period     <= PER_START;
            fcnt       <= '0;
            pts        <= '0;
            hold       <= '0;
            jump_prev  <= 1'b0;
`ifdef GAME_SCHED_HISCORE_EN
            hiscore    <= '0;
`endif
        end else begin
            jump_prev  <= jump;
            enemy_step <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (jp) begin
                        state  <= ST_RUN;
                        run    <= 1'b1;
                        score  <= '0;
                        period <= PER_START;
                        fcnt   <= '0;
                        pts    <= '0;
                    end
                end
                ST_RUN: begin
                    if (frame_tick) begin
                        if (coll) begin
                            state     <= ST_DEAD;
                            run       <= 1'b0;
                            game_over <= 1'b1;
                            hold      <= '0;
`ifdef GAME_SCHED_HISCORE_EN
                            if (score > hiscore)
                                hiscore <= score;
`endif
                        end else begin
                            if (score != SCORE_MAX) begin
                                score <= score + 14'd1;
                                if (pts == PTS_LAST) begin
                                    pts <= '0;
                                    if (period > PER_MIN)
                                        period <= period - 3'd1;
                                end else begin
                                    pts <= pts + 1'b1;
                                end
                            end
                            // A counter left beyond a shortened period just reloads without stepping.
                            if (fcnt >= period - 3'd1) begin
                                fcnt       <= '0;
                                enemy_step <= (fcnt == period - 3'd1);
                            end else begin
                                fcnt <= fcnt + 3'd1;
                            end
                        end
                    end
                end
                ST_DEAD: begin
                    if (frame_tick && (hold != HOLD_MAX))
                        hold <= hold + 1'b1;
                    if (jp && (hold == HOLD_MAX)) begin
                        state     <= ST_IDLE;
                        game_over <= 1'b0;
                        score     <= '0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    run       <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/game_sched.md
Name: game_sched

Overview:
- Game-level controller for the dinosaur runner. Sequences the IDLE/RUN/DEAD game flow and detects player-vs-enemy collisions from the packed game-state bus.
- Keeps the running score and schedules enemy movement steps at a speed that rises with score.
- Sits between the frame-rate tick source and the player/enemy update blocks. Its run and enemy_step outputs gate those blocks; score and game_over feed the display.

Parameters:
- DATALEN, 20, bits per game-state entry; each entry is {y[Y_W-1:0], x[X_W-1:0]}.
- DATACOUNT, 4, number of entries; entry 0 is the player, entries 1..DATACOUNT-1 are enemies.
- X_W, 10, x field width. DATALEN = X_W + Y_W.
- Y_W, 10, y field width.
- OBJ_W, 16, object bounding-box width in pixels; same for all objects.
- OBJ_H, 16, object bounding-box height in pixels.
- START_PERIOD, 4, frames per enemy step at game start.
- MIN_PERIOD, 1, fastest step period.
- SPEEDUP_PTS, 100, score points per period decrement.
- DEAD_HOLD, 30, frame ticks in DEAD before a restart is accepted.

Ports:
- clock  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- frame_tick  in  1  one-cycle pulse per game frame, synchronous to clock.
- jump  in  1  debounced jump button level, synchronous to clock.
- gamedata  in  DATALEN*DATACOUNT  packed object positions; entry i is at [i*DATALEN +: DATALEN].
- run  out  1  high in RUN only; enables the player and enemy update logic.
- game_over  out  1  high in DEAD only.
- enemy_step  out  1  one-cycle enemy advance pulse.
- score  out  14  binary score, 0..9999.
- period  out  3  current step period, for debug/display.

Behaviour:
- Reset (rst low at a clock edge) takes effect at that edge, from any state including mid-game:
  - state=IDLE; run=0, game_over=0, enemy_step=0, score=0, period=START_PERIOD.
  - Internal frame counter and hold counter = 0; jump_prev = 0.
- jump edge: jp = jump & ~jump_prev, where jump_prev is registered every cycle.
- IDLE:
  - Waits for jp. On jp at edge N, state=RUN from edge N+1.
  - At that transition score=0, period=START_PERIOD, frame counter=0.
- RUN:
  - Score: on each frame_tick, score += 1, saturating at 9999.
  - Frame counter: increments on each frame_tick. When it equals period-1 on a frame_tick, it reloads to 0 and enemy_step is asserted on the next cycle for exactly one cycle.
  - Period: when the score increments to a nonzero multiple of SPEEDUP_PTS, period decrements by 1 at the same edge, floored at MIN_PERIOD. The frame counter is not reset by a period change; if the counter is >= the new period, it reloads to 0 at the next frame_tick.
- Collision:
  - Evaluated only on frame_tick cycles in RUN, combinationally on that cycle's gamedata.
  - An enemy with x==0 is inactive and is ignored.
  - Player P and enemy E overlap iff all four hold: Px < Ex+OBJ_W, Ex < Px+OBJ_W, Py < Ey+OBJ_H, Ey < Py+OBJ_H.
  - Compare at X_W+1 / Y_W+1 bits so the sums cannot wrap.
  - If any enemy overlaps: state=DEAD at the next edge. On that frame_tick the score does not increment and no enemy_step is scheduled. Collision has priority over score and step.
- DEAD:
  - run=0, game_over=1; score and period are frozen.
  - Hold counter counts frame_ticks, saturating at DEAD_HOLD.
  - jp is ignored until the hold counter reaches DEAD_HOLD. After that, jp gives state=IDLE at the next edge with score=0.
- Outputs are registered, state-decoded, glitch-free. An enemy_step already scheduled when RUN exits is suppressed.
- Same-cycle jp and frame_tick in IDLE: the transition to RUN wins; that tick is not scored.

Optional Feature:
- Macro: GAME_SCHED_HISCORE_EN.
- Defined:
  - Adds output hiscore (14 bits), reset to 0.
  - On each RUN->DEAD transition, hiscore = max(hiscore, score).
  - Reset clears it; the IDLE restart does not.
- Undefined: no hiscore port or register; all other behaviour is identical.

Test Plan:
- Reset/start: hold rst=0 for 3 cycles -> all outputs 0, period=4. Release, pulse jump high for 5 cycles -> run=1 exactly 1 cycle after the rising edge; holding jump high does not retrigger.
- Step cadence: in RUN, 12 frame_ticks spaced 10 cycles, no overlap -> score=12; enemy_step pulses 3 times, each 1 cycle after the 4th, 8th and 12th tick.
- Speedup: in RUN, drive 100 frame_ticks -> period=3 at the edge where score reaches 100; at score 300 -> period=1; at score 400 -> period stays 1.
- Collision: player at (x=40, y=100), enemy 1 at (x=55, y=110) on a frame_tick -> next edge game_over=1, run=0, score unchanged. Enemy at x=56 -> no collision. Enemy at x=0 overlapping -> ignored.
- Restart hold: in DEAD, jp after 10 ticks -> stays DEAD; jp after the 30th tick -> IDLE next edge, score=0.
- Reset mid-RUN at score=57 -> IDLE, score=0 at the reset edge. With GAME_SCHED_HISCORE_EN: die at score 57, then again at score 20 -> hiscore=57.
